spi_flash_reader: RTL

// - Parametrised SPI NOR flash read engine, successor to the fixed 0x03 read PHY: one request reads 2^size bytes and streams them as 32-bit words.
// - Sits between the flash controller's TileLink-side request logic and the board SPI pins; mode 0 only, single-bit MOSI/MISO.
// - Adds a configurable SCK divider, 3- or 4-byte addressing, response backpressure (SCK stalls) and an enforced CS# deselect time.

---
 rtl/spi_flash_reader.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_reader.sv
// rtl/spi_flash_reader.sv - SPI NOR mode-0 read engine streaming 2^size bytes as 32-bit words.
// Define FLASH_FASTREAD_EN for fast-read (0x0B/0x0C) with an 8-clock dummy phase.
module spi_flash_reader #(
  parameter int ADDR_W       = 24,
  parameter int CLK_DIV      = 2,
  parameter int INIT_CYCLES  = 4096,
  parameter int MAX_SIZE     = 9,
  parameter int DESEL_CYCLES = 4
) (
  input  logic              flash_clock_i,
  input  logic              flash_resetn_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [3:0]        req_size_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_data_o,
  output logic              rsp_last_o,
  output logic              flash_cs_n,
  output logic              flash_sck,
  output logic              flash_mosi,
  input  logic              flash_miso
);

  localparam int HDR_BITS = 8 + ADDR_W;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
`ifdef FLASH_FASTREAD_EN
  localparam logic [7:0] CMD_BYTE  = (ADDR_W == 32) ? 8'h0C : 8'h0B;
  localparam logic       HAS_DUMMY = 1'b1;
`else
  localparam logic [7:0] CMD_BYTE  = (ADDR_W == 32) ? 8'h13 : 8'h03;
  localparam logic       HAS_DUMMY = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_CMD, S_DUMMY, S_DATA, S_DESEL
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [15:0]           r_cnt;
  logic [DIV_W-1:0]      r_div;
  logic                  r_sck;
  logic                  r_cs_n;
  logic [HDR_BITS-1:0]   r_tx;
  logic [12:0]           r_bits;
  logic [4:0]            r_wbits;
  logic [3:0]            r_size;
  logic [31:0]           r_acc;
  logic                  r_done;
  logic                  r_rsp_valid;
  logic                  r_rsp_last;
  logic [31:0]           r_rsp_data;

  logic        w_active;
  logic        w_tick;
  logic        w_stall;
  logic        w_rise;
  logic        w_fall;
  logic        w_accept;
  logic        w_word_end;
  logic        w_hdr_end;
  logic        w_dummy_end;
  logic        w_data_end;
  logic [12:0] w_total_m1;
  logic [4:0]  w_wlen_m1;
  logic [3:0]  w_size_eff;
  logic [31:0] w_acc_next;

  assign w_active    = (r_state == S_CMD) || (r_state == S_DUMMY) || (r_state == S_DATA);
  assign w_tick      = w_active && (r_div == DIV_LAST);
  assign w_total_m1  = (13'd8 << r_size) - 13'd1;
  assign w_wlen_m1   = (r_size == 4'd0) ? 5'd7 : (r_size == 4'd1) ? 5'd15 : 5'd31;
  assign w_word_end  = (r_wbits == w_wlen_m1);
  assign w_hdr_end   = (r_bits == 13'(HDR_BITS - 1));
  assign w_dummy_end = (r_bits == 13'd7);
  assign w_data_end  = (r_bits == w_total_m1);
  // Hold SCK low just before the sample that would complete a word the consumer has not taken.
  assign w_stall     = (r_state == S_DATA) && !r_sck && w_word_end && r_rsp_valid && !rsp_ready_i;
  assign w_rise      = w_tick && !r_sck && !w_stall;
  assign w_fall      = w_tick && r_sck;
  assign w_accept    = (r_state == S_IDLE) && req_valid_i;
  assign w_size_eff  = (req_size_i > 4'(MAX_SIZE)) ? 4'd0 : req_size_i;
  // Bytes land little-endian in the word, each received MSB first.
  assign w_acc_next  = r_acc | ({31'd0, flash_miso} << {r_wbits[4:3], ~r_wbits[2:0]});

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:  if (r_cnt == 16'(INIT_CYCLES - 1)) w_next = S_IDLE;
      S_IDLE:  if (req_valid_i) w_next = S_CMD;
      S_CMD:   if (w_rise && w_hdr_end) w_next = HAS_DUMMY ? S_DUMMY : S_DATA;
      S_DUMMY: if (w_rise && w_dummy_end) w_next = S_DATA;
      S_DATA:  if (w_fall && r_done) w_next = S_DESEL;
      S_DESEL: if ((r_cnt >= 16'(DESEL_CYCLES - 1)) && !r_rsp_valid) w_next = S_IDLE;
      default: w_next = S_INIT;
    endcase
  end

  always_ff @(posedge flash_clock_i or negedge flash_resetn_i) begin
    if (!flash_resetn_i) r_state <= S_INIT;
    else                 r_state <= w_next;
  end

  always_ff @(posedge flash_clock_i or negedge flash_resetn_i) begin
    if (!flash_resetn_i) begin
      r_cnt       <= '0;
      r_div       <= '0;
      r_sck       <= 1'b0;
      r_cs_n      <= 1'b1;
      r_tx        <= '0;
      r_bits      <= '0;
      r_wbits     <= '0;
      r_size      <= '0;
      r_acc       <= '0;
      r_done      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      if ((r_state == S_INIT) || (r_state == S_DESEL)) begin
        if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
      end else begin
        r_cnt <= '0;
      end

      if (!w_active)   r_div <= '0;
      else if (w_tick) begin
        if (!w_stall) r_div <= '0;
      end else         r_div <= r_div + 1'b1;

      if (r_rsp_valid && rsp_ready_i) r_rsp_valid <= 1'b0;

      if (w_accept) begin
        r_cs_n  <= 1'b0;
        r_sck   <= 1'b0;
        r_tx    <= {CMD_BYTE, req_addr_i};
        r_size  <= w_size_eff;
        r_bits  <= '0;
        r_wbits <= '0;
        r_acc   <= '0;
        r_done  <= 1'b0;
      end

      if (w_rise) begin
        r_sck <= 1'b1;
        case (r_state)
          S_CMD:   r_bits <= w_hdr_end ? 13'd0 : r_bits + 13'd1;
          S_DUMMY: r_bits <= w_dummy_end ? 13'd0 : r_bits + 13'd1;
          default: begin
            r_bits <= r_bits + 13'd1;
            if (w_data_end) r_done <= 1'b1;
            if (w_word_end) begin
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= w_acc_next;
              r_rsp_last  <= w_data_end;
              r_acc       <= '0;
              r_wbits     <= '0;
            end else begin
              r_acc   <= w_acc_next;
              r_wbits <= r_wbits + 5'd1;
            end
          end
        endcase
      end

      // Zeros shift in behind the header, so MOSI idles low through dummy and data.
      if (w_fall) begin
        r_sck <= 1'b0;
        r_tx  <= {r_tx[HDR_BITS-2:0], 1'b0};
        if ((r_state == S_DATA) && r_done) r_cs_n <= 1'b1;
      end
    end
  end

  assign req_ready_o = (r_state == S_IDLE);
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp_data;
  assign rsp_last_o  = r_rsp_last;
  assign flash_cs_n  = r_cs_n;
  assign flash_sck   = r_sck;
  assign flash_mosi  = r_tx[HDR_BITS-1];

endmodule
